// File: rtl/hq_tod_encoder.sv
// HaveQuick time-of-day encoder: collects 11 BCD nibbles, then sends a Manchester frame
// (preamble, sync word, data symbols). Optional per-nibble even parity via HQ_TOD_PARITY_EN.
module hq_tod_encoder #(
  parameter int          CLKS_PER_HALF = 4,
  parameter int          PREAMBLE_LEN  = 16,
  parameter logic [15:0] SYNC_WORD     = 16'hEB90
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       tx_out,
  output logic       tx_en,
  output logic       busy,
  output logic       frame_done
);

  localparam int HW = $clog2(CLKS_PER_HALF) + 1;
  localparam logic [HW-1:0] HALF_LAST = HW'(CLKS_PER_HALF - 1);
`ifdef HQ_TOD_PARITY_EN
  localparam int SYM_BITS = 5;
`else
  localparam int SYM_BITS = 4;
`endif
  localparam logic [7:0] PRE_LAST  = 8'(PREAMBLE_LEN - 1);
  localparam logic [7:0] SYNC_LAST = 8'd15;
  localparam logic [7:0] SYM_LAST  = 8'(SYM_BITS - 1);
  localparam logic [3:0] LAST_NIB  = 4'd10;

  typedef enum logic [2:0] {
    S_COLLECT, S_PREAMBLE, S_SYNC, S_DATA, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [3:0]    sym_q, sym_d;
  logic [7:0]    bit_q, bit_d;
  logic [HW-1:0] half_q, half_d;
  logic          phase_q, phase_d;
  logic [3:0]    nib_buf_q [0:10];
  logic [3:0]    nib_buf_d [0:10];

  logic in_ready_q, in_ready_d;
  logic tx_out_q, tx_out_d;
  logic tx_en_q, tx_en_d;
  logic busy_q, busy_d;
  logic frame_done_q, frame_done_d;

  logic       accept;
  logic       half_wrap;
  logic       bit_end;
  logic       line_bit;
  logic [3:0] cur_nib;
  logic [3:0] sync_idx;

  assign accept    = (state_q == S_COLLECT) && in_ready_q && in_valid;
  assign half_wrap = (half_q == HALF_LAST);
  assign bit_end   = half_wrap && phase_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_COLLECT;
      cnt_q        <= '0;
      sym_q        <= '0;
      bit_q        <= '0;
      half_q       <= '0;
      phase_q      <= 1'b0;
      nib_buf_q    <= '{default: '0};
      in_ready_q   <= 1'b0;
      tx_out_q     <= 1'b0;
      tx_en_q      <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sym_q        <= sym_d;
      bit_q        <= bit_d;
      half_q       <= half_d;
      phase_q      <= phase_d;
      nib_buf_q    <= nib_buf_d;
      in_ready_q   <= in_ready_d;
      tx_out_q     <= tx_out_d;
      tx_en_q      <= tx_en_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sym_d     = sym_q;
    bit_d     = bit_q;
    half_d    = half_q;
    phase_d   = phase_q;
    nib_buf_d = nib_buf_q;

    if (state_q == S_PREAMBLE || state_q == S_SYNC || state_q == S_DATA) begin
      if (half_wrap) begin
        half_d  = '0;
        phase_d = ~phase_q;
      end else begin
        half_d = half_q + 1'b1;
      end
    end

    case (state_q)
      S_COLLECT: begin
        if (accept) begin
          nib_buf_d[cnt_q] = in_data;
          if (cnt_q == LAST_NIB) begin
            state_d = S_PREAMBLE;
            cnt_d   = '0;
            sym_d   = '0;
            bit_d   = '0;
            half_d  = '0;
            phase_d = 1'b0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      S_PREAMBLE: begin
        if (bit_end) begin
          if (bit_q == PRE_LAST) begin
            state_d = S_SYNC;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + 8'd1;
          end
        end
      end
      S_SYNC: begin
        if (bit_end) begin
          if (bit_q == SYNC_LAST) begin
            state_d = S_DATA;
            bit_d   = '0;
            sym_d   = '0;
          end else begin
            bit_d = bit_q + 8'd1;
          end
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_q == SYM_LAST) begin
            bit_d = '0;
            if (sym_q == LAST_NIB) state_d = S_DONE;
            else                   sym_d   = sym_q + 4'd1;
          end else begin
            bit_d = bit_q + 8'd1;
          end
        end
      end
      S_DONE: begin
        state_d = S_COLLECT;
        cnt_d   = '0;
      end
      default: state_d = S_COLLECT;
    endcase
  end

  // Outputs are registered from next-state values so the line leads by no extra cycle.
  always_comb begin
    cur_nib  = nib_buf_d[sym_d];
    sync_idx = ~bit_d[3:0];
    line_bit = 1'b0;
    case (state_d)
      S_PREAMBLE: line_bit = 1'b1;
      S_SYNC:     line_bit = SYNC_WORD[sync_idx];
      S_DATA: begin
        case (bit_d[2:0])
          3'd0:    line_bit = cur_nib[3];
          3'd1:    line_bit = cur_nib[2];
          3'd2:    line_bit = cur_nib[1];
          3'd3:    line_bit = cur_nib[0];
`ifdef HQ_TOD_PARITY_EN
          3'd4:    line_bit = ^cur_nib;
`endif
          default: line_bit = 1'b0;
        endcase
      end
      default: line_bit = 1'b0;
    endcase

    tx_en_d      = (state_d == S_PREAMBLE) || (state_d == S_SYNC) || (state_d == S_DATA);
    tx_out_d     = tx_en_d & (line_bit ^ phase_d);
    frame_done_d = (state_d == S_DONE);
    busy_d       = (state_d != S_COLLECT);
    in_ready_d   = (state_d == S_COLLECT);
  end

  assign in_ready   = in_ready_q;
  assign tx_out     = tx_out_q;
  assign tx_en      = tx_en_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_hq_tod_encoder.sv
// Directed bench for hq_tod_encoder: decodes the Manchester line and checks frames,
// handshake, reset abort and back-to-back operation.
module tb_hq_tod_encoder;

  localparam int CPH = 2;
`ifdef HQ_TOD_PARITY_EN
  localparam int         N_BITS    = 87;
  localparam int         EN_CYCLES = 348;
  localparam int         HEAD_W    = 10;
  localparam logic [9:0] HEAD_EXP  = 10'b00011_00101;
`else
  localparam int         N_BITS    = 76;
  localparam int         EN_CYCLES = 304;
  localparam int         HEAD_W    = 8;
  localparam logic [9:0] HEAD_EXP  = 10'b00_0001_0010;
`endif

  logic       clk;
  logic       rst;
  logic [3:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       tx_out;
  logic       tx_en;
  logic       busy;
  logic       frame_done;

  hq_tod_encoder #(
    .CLKS_PER_HALF(CPH),
    .PREAMBLE_LEN (16),
    .SYNC_WORD    (16'hEB90)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .tx_out    (tx_out),
    .tx_en     (tx_en),
    .busy      (busy),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int           n_cmp = 0;
  int           n_err = 0;
  int           fd_cnt = 0;
  logic [3:0]   nibs [0:10];
  logic [127:0] exp_v;
  logic         samp [0:639];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (frame_done === 1'b1) fd_cnt++;
  endtask

  task automatic feed(input bit gap, input string tag);
    int idx = 0;
    int cyc = 0;
    bit acc;
    while (idx < 11 && cyc < 200) begin
      if (gap && (cyc % 2 == 0)) begin
        in_valid = 1'b0;
        in_data  = 4'hF;
      end else begin
        in_valid = 1'b1;
        in_data  = nibs[idx];
      end
      acc = in_valid && (in_ready === 1'b1);
      tick();
      cyc++;
      if (acc) idx++;
    end
    in_data = 4'hF;
    chk({tag, "/accepts"}, idx, 11);
    chk({tag, "/collect_cycles"}, cyc, gap ? 22 : 11);
    chk({tag, "/ready_drop"}, in_ready, 1'b0);
    chk({tag, "/tx_en_start"}, tx_en, 1'b1);
  endtask

  task automatic capture(input string tag);
    int len = 0;
    int bad = 0;
    int rdy = 0;
    int fd0;
    logic [127:0] dec;
    logic [127:0] head;
    fd0  = fd_cnt;
    dec  = '0;
    head = '0;
    while (tx_en === 1'b1 && len < 600) begin
      samp[len] = tx_out;
      if (in_ready !== 1'b0) rdy++;
      len++;
      tick();
    end
    chk({tag, "/tx_en_cycles"}, len, EN_CYCLES);
    for (int b = 0; b < N_BITS; b++) begin
      if (samp[4*b] !== samp[4*b+1] || samp[4*b+2] !== samp[4*b+3] ||
          samp[4*b] === samp[4*b+2])
        bad++;
      dec[b] = samp[4*b];
    end
    chk({tag, "/manchester_errs"}, bad, 0);
    chk({tag, "/frame_bits"}, dec, exp_v);
    for (int k = 0; k < HEAD_W; k++) head = {head[126:0], dec[32+k]};
    chk({tag, "/first_symbols"}, head, {118'd0, HEAD_EXP});
    chk({tag, "/ready_while_busy"}, rdy, 0);
    chk({tag, "/done_pulse"}, {frame_done, busy, tx_out}, 3'b110);
    tick();
    chk({tag, "/after_done"}, {frame_done, in_ready, busy}, 3'b010);
    chk({tag, "/done_count"}, fd_cnt - fd0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] sw;
    int i;
    nibs = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd0, 4'd4, 4'd5, 4'd2, 4'd4};
    sw    = 16'hEB90;
    exp_v = '0;
    i     = 0;
    for (int k = 0; k < 16; k++) begin exp_v[i] = 1'b1; i++; end
    for (int k = 15; k >= 0; k--) begin exp_v[i] = sw[k]; i++; end
    for (int n = 0; n < 11; n++) begin
      for (int k = 3; k >= 0; k--) begin exp_v[i] = nibs[n][k]; i++; end
`ifdef HQ_TOD_PARITY_EN
      exp_v[i] = ^nibs[n];
      i++;
`endif
    end

    // reset values
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 4'h0;
    tick(); tick(); tick();
    chk("reset/outputs", {in_ready, tx_out, tx_en, busy, frame_done}, 5'b0);
    rst = 1'b0;
    tick();
    chk("reset/ready_after_release", {in_ready, tx_en, busy}, 3'b100);

    // full frame, continuous input
    feed(1'b0, "frame");
    capture("frame");
    in_valid = 1'b0;
    tick();

    // gapped input with 0xF on idle cycles
    feed(1'b1, "gapped");
    capture("gapped");
    in_valid = 1'b0;
    tick();

    // reset during SYNC
    feed(1'b0, "abort");
    for (int k = 0; k < 72; k++) tick();
    chk("abort/in_frame", {tx_en, busy}, 2'b11);
    begin
      int fd0;
      fd0 = fd_cnt;
      #2 rst = 1'b1;
      #1 chk("abort/async_clear", {tx_en, tx_out, busy, in_ready}, 4'b0);
      in_valid = 1'b0;
      tick(); tick();
      rst = 1'b0;
      tick();
      chk("abort/ready_after", {in_ready, tx_en}, 2'b10);
      chk("abort/no_done", fd_cnt - fd0, 0);
    end
    feed(1'b0, "post_abort");
    capture("post_abort");
    in_valid = 1'b0;
    tick();

    // back-to-back with in_valid held high throughout
    feed(1'b0, "b2b1");
    capture("b2b1");
    feed(1'b0, "b2b2");
    capture("b2b2");
    in_valid = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
